// File: rtl/bulb_sequencer.sv
// bulb_sequencer: debounced three-bulb controller with break-before-make gaps and a chase mode.
module bulb_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 4,
  parameter int CHASE_CYCLES    = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic S,
  input  logic S1,
  input  logic S2,
  output logic B1,
  output logic B2,
  output logic B3,
  output logic gap_active,
  output logic chase_active
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int CW = $clog2(CHASE_CYCLES + 1);
  typedef enum logic [1:0] {OFF, LIT, GAP, CHASE} state_e;
  state_e        state_q;
  logic [2:0]    meta_q, sync_q, filt_q;
  logic [DW-1:0] db_cnt_q [3];
  logic [GW-1:0] gap_cnt_q;
  logic [CW-1:0] chase_cnt_q;
  logic [2:0]    bulbs_q;
  logic          gap_q, chase_q;
  logic          tgt_none, tgt_chase;
  logic [2:0]    tgt_bulb;
  // Bit 2 carries S, bit 1 S1, bit 0 S2; bulbs are {B1,B2,B3}.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      filt_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      meta_q <= {S, S1, S2};
      sync_q <= meta_q;
      for (int i = 0; i < 3; i++)
        if (sync_q[i] == filt_q[i]) db_cnt_q[i] <= '0;
        else if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          filt_q[i]   <= sync_q[i];
          db_cnt_q[i] <= '0;
        end else db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
    end
  end
  assign tgt_none  = !filt_q[2];
  assign tgt_chase = &filt_q;
  assign tgt_bulb  = (tgt_none || tgt_chase) ? 3'b000 :
                     filt_q[1] ? 3'b100 : filt_q[0] ? 3'b010 : 3'b001;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OFF;
      bulbs_q     <= '0;
      gap_q       <= 1'b0;
      chase_q     <= 1'b0;
      gap_cnt_q   <= '0;
      chase_cnt_q <= '0;
    end else begin
      case (state_q)
        OFF:
          if (tgt_chase) begin
            state_q     <= CHASE;
            bulbs_q     <= 3'b100;
            chase_q     <= 1'b1;
            chase_cnt_q <= '0;
          end else if (!tgt_none) begin
            state_q <= LIT;
            bulbs_q <= tgt_bulb;
          end
        LIT:
          if (tgt_none) begin
            state_q <= OFF;
            bulbs_q <= '0;
          end else if (tgt_bulb != bulbs_q) begin
            state_q   <= GAP;
            bulbs_q   <= '0;
            gap_q     <= 1'b1;
            gap_cnt_q <= '0;
          end
        GAP:
          if (tgt_none) begin
            state_q   <= OFF;
            gap_q     <= 1'b0;
            gap_cnt_q <= '0;
          end else if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
            state_q     <= tgt_chase ? CHASE : LIT;
            bulbs_q     <= tgt_chase ? 3'b100 : tgt_bulb;
            chase_q     <= tgt_chase;
            gap_q       <= 1'b0;
            gap_cnt_q   <= '0;
            chase_cnt_q <= '0;
          end else gap_cnt_q <= gap_cnt_q + GW'(1);
        CHASE:
          if (tgt_none) begin
            state_q     <= OFF;
            bulbs_q     <= '0;
            chase_q     <= 1'b0;
            chase_cnt_q <= '0;
          end else if (!tgt_chase) begin
            state_q     <= GAP;
            bulbs_q     <= '0;
            chase_q     <= 1'b0;
            gap_q       <= 1'b1;
            gap_cnt_q   <= '0;
            chase_cnt_q <= '0;
          end else if (chase_cnt_q == CW'(CHASE_CYCLES - 1)) begin
            bulbs_q     <= {bulbs_q[0], bulbs_q[2:1]};
            chase_cnt_q <= '0;
          end else chase_cnt_q <= chase_cnt_q + CW'(1);
        default: state_q <= OFF;
      endcase
    end
  end
  assign {B1, B2, B3}  = bulbs_q;
  assign gap_active    = gap_q;
  assign chase_active  = chase_q;
endmodule

// File: tb/tb_bulb_sequencer.sv
// tb_bulb_sequencer: directed checks of debounce latency, gaps, bounce rejection, chase and reset.
module tb_bulb_sequencer;
  logic clk = 1'b0, rst = 1'b1, s = 1'b1, s1 = 1'b1, s2 = 1'b0;
  logic b1, b2, b3, gap, chase;
  logic [4:0] outs;
  int n_cmp = 0, n_bad = 0;
  localparam logic [4:0] NONE = 5'b00000, L1 = 5'b10000, L2 = 5'b01000, L3 = 5'b00100, GP = 5'b00010;
  bulb_sequencer #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(2), .CHASE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .S(s), .S1(s1), .S2(s2),
    .B1(b1), .B2(b2), .B3(b3), .gap_active(gap), .chase_active(chase)
  );
  assign outs = {b1, b2, b3, gap, chase};
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(string tag, logic [4:0] got, logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] chase_at(int k);
    case ((k / 8) % 3)
      0:       return 5'b10001;
      1:       return 5'b01001;
      default: return 5'b00101;
    endcase
  endfunction
  initial begin
    for (int r = 1; r <= 3; r++) begin
      tick();
      check($sformatf("reset r%0d", r), outs, NONE);
    end
    rst = 1'b0; s = 1'b0; s1 = 1'b0; s2 = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      tick();
      check($sformatf("idle r%0d", r), outs, NONE);
    end
    s = 1'b1; s1 = 1'b1; s2 = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      tick();
      check($sformatf("sel_b1 r%0d", r), outs, r >= 7 ? L1 : NONE);
    end
    s1 = 1'b0; s2 = 1'b1;
    for (int r = 1; r <= 11; r++) begin
      tick();
      check($sformatf("b1_to_b2 r%0d", r), outs, r <= 6 ? L1 : r <= 8 ? GP : L2);
    end
    s2 = 1'b0;
    for (int r = 1; r <= 11; r++) begin
      tick();
      check($sformatf("b2_to_b3 r%0d", r), outs, r <= 6 ? L2 : r <= 8 ? GP : L3);
    end
    for (int i = 0; i < 20; i++) begin
      s1 = ((i / 2) % 2 == 0);
      tick();
      check($sformatf("bounce i%0d", i), outs, L3);
    end
    s1 = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      tick();
      check($sformatf("post_bounce r%0d", r), outs, L3);
    end
    s = 1'b0;
    for (int r = 1; r <= 9; r++) begin
      tick();
      check($sformatf("b3_off r%0d", r), outs, r <= 6 ? L3 : NONE);
    end
    s = 1'b1; s1 = 1'b1; s2 = 1'b1;
    for (int e = 1; e <= 38; e++) begin
      tick();
      check($sformatf("chase e%0d", e), outs, e < 7 ? NONE : chase_at(e - 7));
    end
    s1 = 1'b0;
    for (int r = 1; r <= 16; r++) begin
      tick();
      if (r == 1) s = 1'b0;
      check($sformatf("off_mid_gap r%0d", r), outs, r <= 6 ? chase_at(31 + r) : r == 7 ? GP : NONE);
    end
    s = 1'b1; s1 = 1'b1;
    for (int r = 1; r <= 16; r++) begin
      tick();
      check($sformatf("chase2 r%0d", r), outs, r < 7 ? NONE : chase_at(r - 7));
    end
    rst = 1'b1;
    tick();
    check("rst_mid_chase", outs, NONE);
    rst = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      tick();
      if (r <= 4) check($sformatf("refill r%0d", r), outs, NONE);
      else if (r >= 7) check($sformatf("restart r%0d", r), outs, chase_at(r - 7));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
